// File: rtl/apb4_timeout_demux.sv
// Registered APB4 demultiplexer: one upstream target port fans out to NoSlv
// downstream ports by address window, with unmapped-address error and hung-slave timeout.
module apb4_timeout_demux #(
    parameter int                   AddrWidth     = 32,
    parameter int                   DataWidth     = 32,
    parameter int                   NoSlv         = 4,
    parameter logic [AddrWidth-1:0] BaseAddr      = '0,
    parameter int                   SlvAddrBits   = 12,
    parameter int                   TimeoutCycles = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [AddrWidth-1:0]        s_paddr_i,
    input  logic [DataWidth-1:0]        s_pwdata_i,
    input  logic                        s_pwrite_i,
    input  logic [DataWidth/8-1:0]      s_pstrb_i,
    input  logic [2:0]                  s_pprot_i,
    input  logic                        s_psel_i,
    input  logic                        s_penable_i,
    output logic [DataWidth-1:0]        s_prdata_o,
    output logic                        s_pready_o,
    output logic                        s_pslverr_o,
    output logic [AddrWidth-1:0]        m_paddr_o,
    output logic [DataWidth-1:0]        m_pwdata_o,
    output logic                        m_pwrite_o,
    output logic [DataWidth/8-1:0]      m_pstrb_o,
    output logic [2:0]                  m_pprot_o,
    output logic [NoSlv-1:0]            m_psel_o,
    output logic                        m_penable_o,
    input  logic [NoSlv*DataWidth-1:0]  m_prdata_i,
    input  logic [NoSlv-1:0]            m_pready_i,
    input  logic [NoSlv-1:0]            m_pslverr_i,
    output logic                        timeout_o
);

    localparam int IdxWidth = (NoSlv > 1) ? $clog2(NoSlv) : 1;
    localparam int CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] win;
    logic                 hit;
    logic [IdxWidth-1:0]  dec_idx;
    logic [IdxWidth-1:0]  sel_idx;
    logic                 setup_req;
    logic                 sel_ready;
    logic                 sel_err;
    logic [DataWidth-1:0] sel_rdata;
    logic                 timed_out;
    logic [CntWidth-1:0]  wait_cnt;
    logic [DataWidth-1:0] resp_data;
    logic                 resp_err;

    // Addresses below BaseAddr are a miss rather than wrapping into a high window.
    assign off       = s_paddr_i - BaseAddr;
    assign win       = off >> SlvAddrBits;
    assign hit       = (s_paddr_i >= BaseAddr) && (win < AddrWidth'(NoSlv));
    assign dec_idx   = win[IdxWidth-1:0];
    assign setup_req = s_psel_i && !s_penable_i;

    assign sel_ready = m_pready_i[sel_idx];
    assign sel_err   = m_pslverr_i[sel_idx];
    assign sel_rdata = m_prdata_i[sel_idx*DataWidth +: DataWidth];

    // wait_cnt counts completed wait cycles; abort once TimeoutCycles of them have elapsed.
    assign timed_out = (TimeoutCycles != 0) && (wait_cnt == CntWidth'(TimeoutCycles));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (setup_req) state_next = hit ? SETUP : RESP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (sel_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_paddr_o   <= '0;
            m_pwdata_o  <= '0;
            m_pwrite_o  <= 1'b0;
            m_pstrb_o   <= '0;
            m_pprot_o   <= '0;
            m_psel_o    <= '0;
            m_penable_o <= 1'b0;
            sel_idx     <= '0;
            wait_cnt    <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (setup_req) begin
                        m_paddr_o  <= s_paddr_i;
                        m_pwdata_o <= s_pwdata_i;
                        m_pwrite_o <= s_pwrite_i;
                        m_pstrb_o  <= s_pwrite_i ? s_pstrb_i : '0;
                        m_pprot_o  <= s_pprot_i;
                        if (hit) begin
                            m_psel_o <= NoSlv'(1) << dec_idx;
                            sel_idx  <= dec_idx;
                        end else begin
                            resp_err  <= 1'b1;
                            resp_data <= '0;
                        end
                    end
                end
                SETUP: begin
                    m_penable_o <= 1'b1;
                    wait_cnt    <= '0;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        m_psel_o    <= '0;
                        m_penable_o <= 1'b0;
                        resp_data   <= sel_rdata;
                        resp_err    <= sel_err;
                    end else if (timed_out) begin
                        m_psel_o    <= '0;
                        m_penable_o <= 1'b0;
                        resp_data   <= '0;
                        resp_err    <= 1'b1;
                        timeout_o   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_pready_o  = (state == RESP);
    assign s_pslverr_o = (state == RESP) ? resp_err : 1'b0;
    assign s_prdata_o  = (state == RESP) ? resp_data : '0;

endmodule

// File: tb/tb_apb4_timeout_demux.sv
// Directed self-checking bench for apb4_timeout_demux with default parameters
// (4 slaves, 4 KiB windows at base 0, 16-cycle timeout).
module tb_apb4_timeout_demux;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [AW-1:0]   s_paddr_i;
    logic [DW-1:0]   s_pwdata_i;
    logic            s_pwrite_i;
    logic [DW/8-1:0] s_pstrb_i;
    logic [2:0]      s_pprot_i;
    logic            s_psel_i;
    logic            s_penable_i;
    logic [DW-1:0]   s_prdata_o;
    logic            s_pready_o;
    logic            s_pslverr_o;
    logic [AW-1:0]   m_paddr_o;
    logic [DW-1:0]   m_pwdata_o;
    logic            m_pwrite_o;
    logic [DW/8-1:0] m_pstrb_o;
    logic [2:0]      m_pprot_o;
    logic [NS-1:0]   m_psel_o;
    logic            m_penable_o;
    logic [NS*DW-1:0] m_prdata_i;
    logic [NS-1:0]   m_pready_i;
    logic [NS-1:0]   m_pslverr_i;
    logic            timeout_o;

    int checks   = 0;
    int failures = 0;

    apb4_timeout_demux #(
        .AddrWidth(AW), .DataWidth(DW), .NoSlv(NS), .BaseAddr('0),
        .SlvAddrBits(12), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_paddr_i(s_paddr_i), .s_pwdata_i(s_pwdata_i), .s_pwrite_i(s_pwrite_i),
        .s_pstrb_i(s_pstrb_i), .s_pprot_i(s_pprot_i), .s_psel_i(s_psel_i),
        .s_penable_i(s_penable_i), .s_prdata_o(s_prdata_o), .s_pready_o(s_pready_o),
        .s_pslverr_o(s_pslverr_o), .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o),
        .m_pwrite_o(m_pwrite_o), .m_pstrb_o(m_pstrb_o), .m_pprot_o(m_pprot_o),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_prdata_i(m_prdata_i),
        .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 ns after the next rising edge; all sampling happens there.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drives the setup cycle T and returns in cycle T+1 with penable raised.
    task automatic start_setup(input logic [AW-1:0] addr, input logic write,
                               input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
        s_psel_i    = 1'b1;
        s_penable_i = 1'b0;
        s_paddr_i   = addr;
        s_pwrite_i  = write;
        s_pwdata_i  = data;
        s_pstrb_i   = strb;
        s_pprot_i   = 3'b010;
        tick();
        s_penable_i = 1'b1;
    endtask

    task automatic end_transfer();
        s_psel_i    = 1'b0;
        s_penable_i = 1'b0;
        m_pready_i  = '0;
        m_pslverr_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({s_pready_o, s_pslverr_o, s_prdata_o, m_psel_o, m_penable_o, timeout_o} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_upstream got pready=%b slverr=%b prdata=%h psel=%b pen=%b to=%b exp all 0",
                     s_pready_o, s_pslverr_o, s_prdata_o, m_psel_o, m_penable_o, timeout_o);
        end
        checks++;
        if ({m_paddr_o, m_pwdata_o, m_pwrite_o, m_pstrb_o, m_pprot_o} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_broadcast got addr=%h wdata=%h wr=%b strb=%h prot=%h exp all 0",
                     m_paddr_o, m_pwdata_o, m_pwrite_o, m_pstrb_o, m_pprot_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        start_setup(32'h0000_1004, 1'b1, 32'hA5A5_1234, 4'hF);
        checks++;
        if (m_psel_o !== 4'b0010 || m_penable_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_setup got psel=%b pen=%b exp psel=0010 pen=0", m_psel_o, m_penable_o);
        end
        checks++;
        if (m_paddr_o !== 32'h0000_1004 || m_pwrite_o !== 1'b1 || m_pstrb_o !== 4'hF || m_pprot_o !== 3'b010) begin
            failures++;
            $display("[TB] FAIL wr_fields got addr=%h wr=%b strb=%h prot=%h exp 00001004 1 f 2",
                     m_paddr_o, m_pwrite_o, m_pstrb_o, m_pprot_o);
        end
        tick();
        checks++;
        if (m_penable_o !== 1'b1 || m_pwdata_o !== 32'hA5A5_1234 || s_pready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_access got pen=%b wdata=%h pready=%b exp 1 a5a51234 0",
                     m_penable_o, m_pwdata_o, s_pready_o);
        end
        m_pready_i = 4'b0010;
        tick();
        checks++;
        if (s_pready_o !== 1'b1 || s_pslverr_o !== 1'b0 || m_psel_o !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL wr_resp got pready=%b slverr=%b psel=%b exp 1 0 0000",
                     s_pready_o, s_pslverr_o, m_psel_o);
        end
        end_transfer();
        tick();
        checks++;
        if (s_pready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_single_pready got pready=%b exp 0", s_pready_o);
        end
    endtask

    task automatic test_read_wait();
        start_setup(32'h0000_3000, 1'b0, 32'h1111_2222, 4'hF);
        checks++;
        if (m_psel_o !== 4'b1000 || m_pstrb_o !== 4'h0 || m_pwrite_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_setup got psel=%b strb=%h wr=%b exp 1000 0 0", m_psel_o, m_pstrb_o, m_pwrite_o);
        end
        tick();
        tick();
        checks++;
        if (s_pready_o !== 1'b0 || m_penable_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rd_wait got pready=%b pen=%b exp 0 1", s_pready_o, m_penable_o);
        end
        tick();
        m_pready_i = 4'b1000;
        m_prdata_i[3*DW +: DW] = 32'hDEAD_BEEF;
        m_prdata_i[0 +: DW]    = 32'h0BAD_0BAD;
        tick();
        checks++;
        if (s_pready_o !== 1'b1 || s_prdata_o !== 32'hDEAD_BEEF || s_pslverr_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_resp got pready=%b prdata=%h slverr=%b exp 1 deadbeef 0",
                     s_pready_o, s_prdata_o, s_pslverr_o);
        end
        end_transfer();
        tick();
        checks++;
        if (s_prdata_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rd_prdata_idle got %h exp 00000000", s_prdata_o);
        end
    endtask

    task automatic test_miss();
        start_setup(32'h0000_4000, 1'b0, 32'h0, 4'h0);
        checks++;
        if (s_pready_o !== 1'b1 || s_pslverr_o !== 1'b1 || s_prdata_o !== 32'h0 || m_psel_o !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL miss_resp got pready=%b slverr=%b prdata=%h psel=%b exp 1 1 0 0000",
                     s_pready_o, s_pslverr_o, s_prdata_o, m_psel_o);
        end
        end_transfer();
        tick();
        checks++;
        if (s_pready_o !== 1'b0 || m_psel_o !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL miss_after got pready=%b psel=%b exp 0 0000", s_pready_o, m_psel_o);
        end
    endtask

    task automatic test_boundary_decode();
        start_setup(32'h0000_3FFC, 1'b1, 32'hCAFE_F00D, 4'h3);
        checks++;
        if (m_psel_o !== 4'b1000 || m_pstrb_o !== 4'h3) begin
            failures++;
            $display("[TB] FAIL top_window got psel=%b strb=%h exp 1000 3", m_psel_o, m_pstrb_o);
        end
        tick();
        m_pready_i = 4'b1000;
        tick();
        end_transfer();
        tick();
        start_setup(32'h0000_0FFF, 1'b0, 32'h0, 4'h0);
        checks++;
        if (m_psel_o !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL low_window got psel=%b exp 0001", m_psel_o);
        end
        tick();
        m_pready_i = 4'b0001;
        tick();
        end_transfer();
        tick();
    endtask

    task automatic test_timeout();
        int bad = 0;
        start_setup(32'h0000_0010, 1'b0, 32'h0, 4'h0);
        for (int c = 1; c <= 17; c++) begin
            if (s_pready_o !== 1'b0 || timeout_o !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL to_early got %0d early responses exp 0", bad);
        end
        checks++;
        if (m_psel_o !== 4'b0001 || s_pready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_t18 got psel=%b pready=%b exp 0001 0", m_psel_o, s_pready_o);
        end
        tick();
        checks++;
        if (s_pready_o !== 1'b1 || s_pslverr_o !== 1'b1 || timeout_o !== 1'b1 || s_prdata_o !== 32'h0
            || m_psel_o !== 4'b0000 || m_penable_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_resp got pready=%b slverr=%b to=%b prdata=%h psel=%b pen=%b exp 1 1 1 0 0000 0",
                     s_pready_o, s_pslverr_o, timeout_o, s_prdata_o, m_psel_o, m_penable_o);
        end
        end_transfer();
        tick();
        checks++;
        if (timeout_o !== 1'b0 || s_pready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_pulse got to=%b pready=%b exp 0 0", timeout_o, s_pready_o);
        end
        for (int c = 0; c < 5; c++) tick();
        m_pready_i = 4'b0001;
        m_pslverr_i = 4'b0001;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (s_pready_o !== 1'b0 || m_psel_o !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL to_stray got %0d stray responses exp 0", bad);
        end
        end_transfer();
        tick();
    endtask

    task automatic test_back_to_back();
        start_setup(32'h0000_2008, 1'b0, 32'h0, 4'h0);
        tick();
        m_pready_i  = 4'b0100;
        m_pslverr_i = 4'b0100;
        m_prdata_i[2*DW +: DW] = 32'h5555_AAAA;
        tick();
        checks++;
        if (s_pready_o !== 1'b1 || s_pslverr_o !== 1'b1 || s_prdata_o !== 32'h5555_AAAA) begin
            failures++;
            $display("[TB] FAIL b2b_err got pready=%b slverr=%b prdata=%h exp 1 1 5555aaaa",
                     s_pready_o, s_pslverr_o, s_prdata_o);
        end
        end_transfer();
        tick();
        start_setup(32'h0000_0040, 1'b0, 32'h0, 4'h0);
        checks++;
        if (m_psel_o !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL b2b_setup got psel=%b exp 0001", m_psel_o);
        end
        tick();
        m_pready_i  = 4'b1111;
        m_pslverr_i = 4'b1110;
        m_prdata_i[0 +: DW] = 32'h1234_5678;
        tick();
        checks++;
        if (s_pready_o !== 1'b1 || s_pslverr_o !== 1'b0 || s_prdata_o !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL b2b_second got pready=%b slverr=%b prdata=%h exp 1 0 12345678",
                     s_pready_o, s_pslverr_o, s_prdata_o);
        end
        end_transfer();
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        start_setup(32'h0000_1000, 1'b1, 32'h7777_8888, 4'hF);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        checks++;
        if (m_psel_o !== 4'b0000 || m_penable_o !== 1'b0 || s_pready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid got psel=%b pen=%b pready=%b exp 0000 0 0",
                     m_psel_o, m_penable_o, s_pready_o);
        end
        rst_i = 1'b0;
        end_transfer();
        tick();
        test_write_zero_wait();
    endtask

    initial begin
        rst_i       = 1'b1;
        s_paddr_i   = '0;
        s_pwdata_i  = '0;
        s_pwrite_i  = 1'b0;
        s_pstrb_i   = '0;
        s_pprot_i   = '0;
        s_psel_i    = 1'b0;
        s_penable_i = 1'b0;
        m_prdata_i  = '0;
        m_pready_i  = '0;
        m_pslverr_i = '0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_miss();
        test_boundary_decode();
        test_timeout();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
